// File: rtl/spi_nor_reader.sv
// rtl/spi_nor_reader.sv - SPI NOR 1-1-1 read initiator with sequential-stream continuation
module spi_nor_reader #(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter int         CSB_IDLE = 2,
    parameter int         HOLD_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [23:0] addr,
    output logic        ready,
    output logic [7:0]  rdata,
    output logic        nor_sck,
    output logic        nor_csb,
    output logic        nor_si,
    input  logic        nor_so
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam int GAP_W  = $clog2(CSB_IDLE + 1);

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [4:0]          r_bit;
    logic [30:0]         r_tx;
    logic [7:0]          r_rx;
    logic [23:0]         r_next;
    logic [HOLD_W-1:0]   r_hold;
    logic [GAP_W-1:0]    r_gap;
    logic                r_sck;
    logic                r_csb;
    logic                r_si;
    logic                r_ready;
    logic [7:0]          r_rdata;

    assign nor_sck = r_sck;
    assign nor_csb = r_csb;
    assign nor_si  = r_si;
    assign ready   = r_ready;
    assign rdata   = r_rdata;

    // Loading r_div with CLK_DIV (not CLK_DIV-1) gives one setup cycle before the
    // first sck low phase, so si/csb are settled a full half-period before the rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_next  <= '0;
            r_hold  <= '0;
            r_gap   <= '0;
            r_sck   <= 1'b0;
            r_csb   <= 1'b1;
            r_si    <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_csb   <= 1'b0;
                        r_sck   <= 1'b0;
                        r_si    <= READ_CMD[7];
                        r_tx    <= {READ_CMD[6:0], addr};
                        r_next  <= addr + 24'd1;
                        r_bit   <= '0;
                        r_div   <= DIV_W'(CLK_DIV);
                        r_state <= S_CMD;
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    if (r_div != '0) begin
                        r_div <= r_div - 1'b1;
                    end else begin
                        r_div <= DIV_W'(CLK_DIV - 1);
                        r_sck <= ~r_sck;
                        if (!r_sck) begin
                            r_rx <= {r_rx[6:0], nor_so};
                        end else begin
                            r_bit <= r_bit + 5'd1;
                            r_tx  <= {r_tx[29:0], 1'b0};
                            r_si  <= r_tx[30];
                            if (r_state == S_CMD && r_bit == 5'd7) begin
                                r_state <= S_ADDR;
                                r_bit   <= '0;
                            end else if (r_state == S_ADDR && r_bit == 5'd23) begin
                                r_state <= S_DATA;
                                r_bit   <= '0;
                                r_si    <= 1'b0;
                            end else if (r_state == S_DATA) begin
                                r_si <= 1'b0;
                                if (r_bit == 5'd7) begin
                                    r_state <= S_HOLD;
                                    r_ready <= 1'b1;
                                    r_rdata <= r_rx;
                                    r_hold  <= '0;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    // req seen during the ready cycle still belongs to the finished byte
                    if (req && !r_ready) begin
                        if (addr == r_next) begin
                            r_next  <= r_next + 24'd1;
                            r_bit   <= '0;
                            r_div   <= DIV_W'(CLK_DIV);
                            r_state <= S_DATA;
                        end else begin
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end
                    end else if (r_hold == HOLD_W'(HOLD_MAX - 1)) begin
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_GAP: begin
                    r_csb <= 1'b1;
                    if (r_gap == GAP_W'(CSB_IDLE - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_csb   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_nor_reader.sv
// tb/tb_spi_nor_reader.sv - randomized bench for spi_nor_reader with a SPI flash model and timing model
module tb_spi_nor_reader;

    localparam int CLK_DIV  = 2;
    localparam int CSB_IDLE = 2;
    localparam int HOLD_MAX = 64;
    localparam int FRESH    = 1 + 80 * CLK_DIV;
    localparam int CONT     = 1 + 16 * CLK_DIV;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        req     = 1'b0;
    logic [23:0] addr    = '0;
    logic        nor_so  = 1'b0;
    logic        ready;
    logic [7:0]  rdata;
    logic        nor_sck;
    logic        nor_csb;
    logic        nor_si;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    bit          stream_open = 1'b0;
    int          last_ready  = 0;
    logic [23:0] next_a      = '0;
    bit          expecting   = 1'b0;
    logic [7:0]  hold_val    = '0;
    logic [23:0] exp_addr    = '0;

    int          fbits     = 0;
    logic [31:0] fsh       = '0;
    logic [23:0] fptr      = '0;
    int          ncmd      = 0;
    int          ncsb_rise = 0;
    int          hi_cnt    = 0;
    int          last_gap  = 0;

    spi_nor_reader #(
        .CLK_DIV (CLK_DIV),
        .READ_CMD(8'h03),
        .CSB_IDLE(CSB_IDLE),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .addr   (addr),
        .ready  (ready),
        .rdata  (rdata),
        .nor_sck(nor_sck),
        .nor_csb(nor_csb),
        .nor_si (nor_si),
        .nor_so (nor_so)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA5;
            24'h000011: return 8'h5A;
            24'h000012: return 8'hC3;
            default:    return (a[7:0] * 8'd37) ^ a[15:8] ^ (a[23:16] + 8'h5C);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flash side: decode opcode+address, then stream bytes out on falling sck.
    always @(negedge nor_csb) fbits = 0;
    always @(posedge nor_csb) ncsb_rise++;

    always @(posedge nor_sck) begin
        if (nor_csb === 1'b0) begin
            if (fbits < 32) fsh = {fsh[30:0], nor_si};
            fbits++;
            if (fbits == 32) begin
                ncmd++;
                chk("cmd_opcode", fsh[31:24], 32'h03);
                chk("cmd_addr", fsh[23:0], exp_addr);
                fptr = fsh[23:0];
            end
        end
    end

    always @(negedge nor_sck) begin
        if (nor_csb === 1'b0 && fbits >= 32) begin
            int          k;
            logic [23:0] a;
            logic [7:0]  b;
            k      = fbits - 32;
            a      = fptr + 24'(k / 8);
            b      = mem(a);
            nor_so = b[7 - (k % 8)];
        end
    end

    always @(negedge clk) begin
        if (nor_csb) hi_cnt++;
        else begin
            if (hi_cnt > 0) last_gap = hi_cnt;
            hi_cnt = 0;
        end
        if (!rst) begin
            if (!expecting) chk("spurious_ready", ready, 0);
            if (!ready) chk("rdata_hold", rdata, hold_val);
        end
    end

    task automatic do_read(input logic [23:0] a, input int idle, input bit drop, input int pin_lat);
        int e, r, lat, lat_exp, c0, cr0, t;
        bit fresh, got;
        @(posedge clk); #1;
        repeat (idle) begin @(posedge clk); #1; end
        e = cyc + 1;
        if (stream_open && (e - last_ready) <= HOLD_MAX) begin
            fresh   = (a != next_a);
            lat_exp = fresh ? (1 + CSB_IDLE + FRESH) : CONT;
        end else begin
            fresh   = 1'b1;
            t       = stream_open ? (last_ready + HOLD_MAX + CSB_IDLE + 1) : e;
            lat_exp = ((t > e) ? t : e) - e + FRESH;
        end
        exp_addr  = a;
        c0        = ncmd;
        cr0       = ncsb_rise;
        req       = 1'b1;
        addr      = a;
        expecting = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (drop && cyc == e + 4) req = 1'b0;
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        r   = cyc;
        lat = r - e;
        chk("ready_seen", got, 1);
        chk("latency", lat, lat_exp);
        if (pin_lat > 0) chk("latency_literal", lat, pin_lat);
        chk("rdata", rdata, mem(a));
        chk("cmd_count", ncmd - c0, fresh);
        if (!fresh) chk("csb_toggles", ncsb_rise - cr0, 0);
        hold_val    = mem(a);
        stream_open = 1'b1;
        last_ready  = r;
        next_a      = a + 24'd1;
        req         = 1'b0;
        @(posedge clk); #1;
        expecting = 1'b0;
    endtask

    initial begin
        logic [23:0] ra;
        int          ridle;
        bit          rdrop;
        bit          got6;
        int          cr6;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_csb", nor_csb, 1);
        chk("reset_sck", nor_sck, 0);
        chk("reset_si", nor_si, 0);
        chk("reset_ready", ready, 0);
        chk("reset_rdata", rdata, 0);
        rst = 1'b0;

        do_read(24'h000010, 0, 1'b0, 161);
        chk("t1_rdata", rdata, 8'hA5);
        do_read(24'h000011, 0, 1'b0, 33);
        chk("t2_rdata_a", rdata, 8'h5A);
        do_read(24'h000012, 0, 1'b0, 33);
        chk("t2_rdata_b", rdata, 8'hC3);

        do_read(24'h000100, 0, 1'b0, 164);
        chk("t3_csb_gap", last_gap, 2);

        repeat (70) @(posedge clk);
        #1;
        chk("t4_csb_released", nor_csb, 1);
        do_read(24'h000101, 0, 1'b0, 161);

        do_read(24'hFFFFFF, 0, 1'b0, 164);
        do_read(24'h000000, 0, 1'b0, 33);
        do_read(24'h000001, 2, 1'b1, 33);

        @(posedge clk); #1;
        exp_addr = 24'h000345;
        cr6      = ncsb_rise;
        req      = 1'b1;
        addr     = 24'h000345;
        got6     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ncsb_rise > cr6 && nor_csb == 1'b0 && fbits >= 18) begin
                got6 = 1'b1;
                break;
            end
        end
        chk("t6_reached_addr", got6, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_csb", nor_csb, 1);
        chk("t6_async_sck", nor_sck, 0);
        chk("t6_async_ready", ready, 0);
        req         = 1'b0;
        hold_val    = '0;
        stream_open = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_read(24'h000010, 0, 1'b0, 161);
        chk("t6_rdata", rdata, 8'hA5);

        for (int n = 0; n < 40; n++) begin
            ra    = ($urandom_range(0, 1) == 1) ? next_a : 24'($urandom);
            ridle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(HOLD_MAX + 2, HOLD_MAX + 20))
                                               : int'($urandom_range(0, 8));
            rdrop = ($urandom_range(0, 7) == 0);
            do_read(ra, ridle, rdrop, -1);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
